// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU main controller: sequences memory, register file, ALU and PC per opcode.
// Optional performance counters (cyc_cnt_o, instr_cnt_o) are enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl_fsm #(
    parameter int WAIT_LIMIT      = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        reg_write_o,
    output logic [1:0]  reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        halt_o,
`ifdef MC_CTRL_PERF_CNT_EN
    output logic        err_o,
    output logic [31:0] cyc_cnt_o,
    output logic [31:0] instr_cnt_o
`else
    output logic        err_o
`endif
);

    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b101100;
    localparam logic [5:0] OP_SW    = 6'b100100;
    localparam logic [5:0] OP_BEQ   = 6'b000110;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_BRANCH, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_opcode;
    logic [CNT_W-1:0] r_wait;
    logic             r_err;
    logic             w_mem_state;
    logic             w_timeout;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

    // The cycle whose increment would reach WAIT_LIMIT is the last allowed wait.
    assign w_timeout = (WAIT_LIMIT != 0) && w_mem_state && !mem_ready_i
                       && (r_wait == CNT_W'(WAIT_LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_wait   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode_i;
            end
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_mem_state && !mem_ready_i) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // NOTE: every output and w_next gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next       = r_state;
        mem_req_o    = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'b00;
        mem_to_reg_o = 1'b0;
        halt_o       = 1'b0;

        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req_o   = 1'b1;
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i)    w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW: w_next = S_EXEC;
                    OP_BEQ, OP_BNE:                  w_next = S_BRANCH;
                    default: w_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (r_opcode)
                    OP_RTYPE: begin
                        alu_src_b_o = 2'b00;
                        alu_op_o    = 2'b10;
                        w_next      = S_R_WB;
                    end
                    OP_ADDI: w_next = S_I_WB;
                    OP_LW:   w_next = S_MEM_RD;
                    OP_SW:   w_next = S_MEM_WR;
                    default: w_next = S_FETCH;
                endcase
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_src_o    = 2'b01;
                pc_write_o  = ((r_opcode == OP_BEQ) && zero_i) || ((r_opcode == OP_BNE) && !zero_i);
                w_next      = S_FETCH;
            end
            S_MEM_RD: begin
                mem_req_o  = 1'b1;
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i)    w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_HALT;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i)    w_next = S_FETCH;
                else if (w_timeout) w_next = S_HALT;
            end
            S_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 2'b01;
                w_next      = S_FETCH;
            end
            S_I_WB: begin
                reg_write_o = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT:  halt_o = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    assign err_o = r_err;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_instr_cnt;

    // An instruction retires whenever FETCH is re-entered from any working state.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end
            if ((w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_IDLE)) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cyc_cnt_o   = r_cyc_cnt;
    assign instr_cnt_o = r_instr_cnt;
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle main controller that sequences the shared single-port memory, register file, ALU and PC of the multi-cycle CPU variant.
- Supported ISA: R-type 000000, ADDI 001001, LW 101100, SW 100100, BEQ 000110, BNE 000101.
- Sits between the instruction register opcode field and the datapath muxes and enables, replacing the combinational decoder.
- Handles a ready-based memory handshake, a wait timeout, and an illegal-opcode halt.

Parameters:
- WAIT_LIMIT, 16: max cycles spent waiting for mem_ready_i in one memory state before error halt; 0 disables the timeout.
- HALT_ON_ILLEGAL, 1: 1 = unknown opcode enters HALT; 0 = treated as NOP (back to FETCH).

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode_i  in  6  instr[31:26] from IR
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the access this cycle
- mem_req_o  out  1  memory access request
- iord_o  out  1  0: address = PC, 1: address = ALUOut
- mem_read_o  out  1
- mem_write_o  out  1
- ir_write_o  out  1
- pc_write_o  out  1
- pc_src_o  out  2  00: ALU result, 01: ALUOut
- alu_src_a_o  out  1  0: PC, 1: reg A
- alu_src_b_o  out  2  00: B, 01: const 4, 10: sext imm, 11: sext imm<<2
- alu_op_o  out  2  00 add, 01 sub, 10 funct
- reg_write_o  out  1
- reg_dst_o  out  2  00: rt, 01: rd
- mem_to_reg_o  out  1
- halt_o  out  1
- err_o  out  1  timeout flag

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, BRANCH, MEM_RD, MEM_WB, MEM_WR, R_WB, I_WB, HALT.
- Reset (async, any time, including mid-access): state = IDLE, wait counter = 0, latched opcode = 0. Every output is 0 immediately.
- IDLE: all outputs 0; goes to FETCH on the next cycle.
- Outputs are Moore-decoded from state, except ir_write_o and pc_write_o, which also depend on inputs as noted below.
- Any output not listed for a state is 0.
- FETCH:
  - Drives mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write = mem_ready_i.
  - Stays in FETCH while mem_ready_i=0; goes to DECODE when mem_ready_i=1.
- DECODE:
  - Latches opcode_i internally; all later decisions use the latched copy.
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: R-type→EXEC, ADDI/LW/SW→EXEC, BEQ/BNE→BRANCH.
  - Other opcodes: HALT if HALT_ON_ILLEGAL=1, else FETCH.
- EXEC:
  - R-type drives alu_src_a=1, alu_src_b=00, alu_op=10, then goes to R_WB.
  - ADDI/LW/SW drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to I_WB, MEM_RD or MEM_WR respectively.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write = (BEQ & zero_i) | (BNE & ~zero_i).
  - Next state FETCH.
- MEM_RD: mem_req=1, mem_read=1, iord=1; waits for mem_ready_i, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=1; next state FETCH.
- MEM_WR: mem_req=1, mem_write=1, iord=1; waits for mem_ready_i, then goes to FETCH.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=0; next state FETCH.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=0; next state FETCH.
- HALT: halt_o=1, all other outputs 0 except a sticky err_o; leaves only on reset.
- Wait counter:
  - $clog2(WAIT_LIMIT+1) bits.
  - Cleared on entry to any memory state; increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready_i=0.
  - If it reaches WAIT_LIMIT while mem_ready_i is still 0, next state is HALT with err_o=1.
  - If mem_ready_i=1 arrives in the same cycle the limit is hit, ready wins and the FSM advances normally.
- Latency with mem_ready_i tied 1:
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ/BNE: 3 cycles.

Optional Feature:
- Macro MC_CTRL_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt_o[31:0] and instr_cnt_o[31:0], both reset to 0.
  - cyc_cnt_o increments every cycle outside IDLE and HALT.
  - instr_cnt_o increments on every transition into FETCH from a non-IDLE state (instruction retired).
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, mem_ready_i=1, opcode 000000: sequence IDLE,FETCH,DECODE,EXEC,R_WB; reg_write=1 and reg_dst=01 in cycle 5; back to FETCH in cycle 6.
- LW (101100) with mem_ready_i low for 3 cycles in MEM_RD: mem_req held 3+1 cycles; MEM_WB asserts mem_to_reg=1, reg_write=1; no timeout.
- BEQ with zero_i=1 → pc_write=1, pc_src=01 in BRANCH; BNE with zero_i=1 → pc_write=0.
- Opcode 111111 with HALT_ON_ILLEGAL=1 → halt_o=1 from the cycle after DECODE, held for 20 cycles; with 0 → FETCH follows DECODE.
- mem_ready_i held 0 in FETCH, WAIT_LIMIT=16 → HALT with err_o=1 after 16 wait cycles; then drop rst_n mid-sequence → all outputs 0 asynchronously, restart from IDLE.
- With MC_CTRL_PERF_CNT_EN: run ADDI,SW,BNE with ready tied 1 → instr_cnt_o=3, cyc_cnt_o=11 at the fourth FETCH entry.
